// File: rtl/fpf_dec_sched_pkg.sv
// Shared FPF constants: Fibonacci weights FNS(1..21) and the width that holds their full sum.
package fpf_dec_sched_pkg;

  localparam int unsigned FNS01 = 1;
  localparam int unsigned FNS02 = 2;
  localparam int unsigned FNS03 = 3;
  localparam int unsigned FNS04 = 5;
  localparam int unsigned FNS05 = 8;
  localparam int unsigned FNS06 = 13;
  localparam int unsigned FNS07 = 21;
  localparam int unsigned FNS08 = 34;
  localparam int unsigned FNS09 = 55;
  localparam int unsigned FNS10 = 89;
  localparam int unsigned FNS11 = 144;
  localparam int unsigned FNS12 = 233;
  localparam int unsigned FNS13 = 377;
  localparam int unsigned FNS14 = 610;
  localparam int unsigned FNS15 = 987;
  localparam int unsigned FNS16 = 1597;
  localparam int unsigned FNS17 = 2584;
  localparam int unsigned FNS18 = 4181;
  localparam int unsigned FNS19 = 6765;
  localparam int unsigned FNS20 = 10946;
  localparam int unsigned FNS21 = 17711;

  // Sum of all 21 weights is 46366, so 16 bits never overflow.
  localparam int unsigned FBLEN21 = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

endpackage

// File: rtl/fpf_dec_sched_wt_sel.sv
// Weight lookup: bit index 0..20 -> FNS(index+1); anything else yields zero.
module fpf_wt_sel_21
  import fpf_dec_sched_pkg::*;
#(
  parameter int unsigned DW = FBLEN21
) (
  input  logic [4:0]    idx_i,
  output logic [DW-1:0] wt_o
);

  always_comb begin
    wt_o = '0;
    case (idx_i)
      5'd0:  wt_o = DW'(FNS01);
      5'd1:  wt_o = DW'(FNS02);
      5'd2:  wt_o = DW'(FNS03);
      5'd3:  wt_o = DW'(FNS04);
      5'd4:  wt_o = DW'(FNS05);
      5'd5:  wt_o = DW'(FNS06);
      5'd6:  wt_o = DW'(FNS07);
      5'd7:  wt_o = DW'(FNS08);
      5'd8:  wt_o = DW'(FNS09);
      5'd9:  wt_o = DW'(FNS10);
      5'd10: wt_o = DW'(FNS11);
      5'd11: wt_o = DW'(FNS12);
      5'd12: wt_o = DW'(FNS13);
      5'd13: wt_o = DW'(FNS14);
      5'd14: wt_o = DW'(FNS15);
      5'd15: wt_o = DW'(FNS16);
      5'd16: wt_o = DW'(FNS17);
      5'd17: wt_o = DW'(FNS18);
      5'd18: wt_o = DW'(FNS19);
      5'd19: wt_o = DW'(FNS20);
      5'd20: wt_o = DW'(FNS21);
      default: wt_o = '0;
    endcase
  end

endmodule

// File: rtl/fpf_dec_sched.sv
// Round-robin shared FPF decoder: grants one requester, decodes one bit per cycle, holds the result.
module fpf_dec_sched
  import fpf_dec_sched_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 21,
  parameter int unsigned DW  = FBLEN21
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH*CW-1:0]       req_code,
  output logic [NCH-1:0]          req_ready,
  output logic                    out_valid,
  output logic [DW-1:0]           out_data,
  output logic [$clog2(NCH)-1:0]  out_ch,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int unsigned CHW  = $clog2(NCH);
  localparam int unsigned CNTW = $clog2(CW);

  state_t          state_q, state_d;
  logic [CW-1:0]   code_q, code_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [CHW-1:0]  out_ch_q, out_ch_d;
  logic [CHW-1:0]  last_q, last_d;

  logic            grant_vld;
  logic [CHW-1:0]  grant_idx;
  logic [CHW-1:0]  cand;
  logic [DW-1:0]   wt;
  logic [DW-1:0]   addend;

  fpf_wt_sel_21 #(.DW(DW)) u_wt_sel (
    .idx_i (5'(cnt_q)),
    .wt_o  (wt)
  );

  assign addend = code_q[cnt_q] ? wt : '0;

  // Search starts one past the last grant; CHW-bit wrap gives the modulo since NCH is a power of two.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = last_q + CHW'(i);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    last_d     = last_q;
    req_ready  = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld && rst_n) begin
          req_ready[grant_idx] = 1'b1;
          code_d   = req_code[grant_idx*CW +: CW];
          out_ch_d = grant_idx;
          last_d   = grant_idx;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        acc_d = acc_q + addend;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTW'(CW - 1)) begin
          out_data_d = acc_q + addend;
          cnt_d      = '0;
          state_d    = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      code_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      last_q     <= CHW'(NCH - 1);
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      last_q     <= last_d;
    end
  end

  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_fpf_dec_sched.sv
// Scoreboard bench for fpf_dec_sched: stimulus pushes expected results, a monitor pops on each output handshake.
module tb_fpf_dec_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [83:0]  req_code;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [15:0]  out_data;
  logic [1:0]   out_ch;
  logic         out_ready;
  logic         busy;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  ch;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          acc_cyc  = 0;
  bit          prev_ov  = 1'b0;
  logic [15:0] last_want;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fpf_dec_sched #(.NCH(4), .CW(21), .DW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, want);
    end
  endtask

  // Independent reference: weights generated as a running Fibonacci series 1,2,3,5,...
  function automatic logic [15:0] ref_sum(input logic [20:0] c);
    int unsigned a = 1, b = 2, s = 0, t;
    for (int k = 0; k < 21; k++) begin
      if (c[k]) s += a;
      t = a + b;
      a = b;
      b = t;
    end
    return s[15:0];
  endfunction

  task automatic push_exp(input logic [15:0] d, input int ch);
    exp_t e;
    e.data = d;
    e.ch   = ch[1:0];
    sb.push_back(e);
    last_want = d;
  endtask

  task automatic set_code(input int ch, input logic [20:0] c);
    req_code[ch*21 +: 21] = c;
  endtask

  task automatic send(input int ch, input logic [20:0] c, input logic [15:0] want);
    bit got = 1'b0;
    @(posedge clk); #1;
    set_code(ch, c);
    req_valid[ch] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready[ch]) begin
        got = 1'b1;
        push_exp(want, ch);
      end
    end
    if (!got) check("grant_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (|req_ready) acc_cyc = cyc + 1;
      if (out_valid && !prev_ov) check("latency", cyc - acc_cyc + 1, 22);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", {30'd0, out_ch}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_ch", out_ch, e.ch);
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    int          prev_g;
    logic [3:0]  order [5];
    logic [15:0] sval  [4];
    logic [20:0] rc;

    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    sval[0] = 16'd3; sval[1] = 16'd8; sval[2] = 16'd55; sval[3] = 16'd10946;

    rst_n = 1'b0; req_valid = '0; req_code = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    send(0, 21'h000001, 16'd1);
    drain();
    send(2, 21'h1FFFFF, 16'd46366);
    drain();
    send(1, 21'h100000, 16'd17711);
    drain();

    // All four requesting from reset release.
    @(posedge clk); #1 rst_n = 1'b0;
    set_code(0, 21'h000003); set_code(1, 21'h000010);
    set_code(2, 21'h000100); set_code(3, 21'h080000);
    req_valid = 4'b1111;
    @(negedge clk);
    check("rst_req_ready_valid", req_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    prev_g = 0;
    for (int n = 0; n < 5; n++) begin
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
        @(negedge clk);
        if (|req_ready) got = 1'b1;
      end
      if (!got) check("rr_timeout", 0, 1);
      check("rr_order", req_ready, order[n]);
      if (n > 0) check("rr_spacing", cyc - prev_g, 23);
      prev_g = cyc;
      push_exp(sval[n % 4], n % 4);
      @(posedge clk);
    end
    #1 req_valid = '0;
    drain();

    // Downstream stall while another channel waits.
    @(posedge clk); #1 out_ready = 1'b0;
    set_code(3, 21'h000005);
    req_valid[3] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (req_ready[3]) got = 1'b1;
    end
    if (!got) check("stall_grant_timeout", 0, 1);
    push_exp(16'd4, 3);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    set_code(0, 21'h000001);
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    if (!got) check("stall_out_timeout", 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 4);
      check("stall_ch", out_ch, 3);
      check("stall_req_ready", req_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("resume_grant", req_ready, 4'b0001);
    push_exp(16'd1, 0);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    drain();

    // Reset in the middle of a ch3 decode.
    send(3, 21'h000040, 16'd21);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    set_code(3, 21'h000040); set_code(1, 21'h000002);
    req_valid = 4'b1010;
    @(negedge clk);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_req_ready", req_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (|req_ready) got = 1'b1;
    end
    check("post_rst_grant", req_ready, 4'b0010);
    push_exp(16'd2, 1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (req_ready[3]) got = 1'b1;
    end
    if (!got) check("ch3_regrant_timeout", 0, 1);
    push_exp(16'd21, 3);
    @(posedge clk); #1 req_valid[3] = 1'b0;
    drain();

    for (int ch = 0; ch < 4; ch++) begin
      for (int r = 0; r < 2; r++) begin
        rc = 21'($urandom);
        send(ch, rc, ref_sum(rc));
      end
    end
    drain();

    // Idle with out_ready high: nothing emitted, last result retained.
    repeat (5) @(negedge clk);
    check("idle_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_data_held", out_data, last_want);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
